audio_stream_reader: RTL and testbench

AUDIO_STREAM_READER -- requirements
Module: audio_stream_reader

---
 rtl/audio_stream_reader_pkg.sv | 24 ++
 rtl/audio_stream_reader_if.sv | 20 ++
 rtl/audio_stream_reader_fifo.sv | 54 +++++
 rtl/audio_stream_reader.sv | 143 ++++++++++++++
 tb/tb_audio_stream_reader.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_stream_reader_pkg.sv
// Shared types and defaults for the audio stream reader.
// Optional macro AUDIO_READER_BYTESWAP_EN: fetched words are byte-swapped before entering the FIFO.
package audio_stream_pkg;
  localparam int SAMPLE_W = 16;
  localparam int ADDR_W = 25;
  localparam logic [ADDR_W-1:0] HALF_WORDS_DEF = 25'h0800000;
  localparam int FIFO_DEPTH_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LOAD,
    FETCH,
    WAIT_DATA,
    DRAIN
  } state_t;

  function automatic logic [SAMPLE_W-1:0] order_word(input logic [SAMPLE_W-1:0] w);
`ifdef AUDIO_READER_BYTESWAP_EN
    return {w[7:0], w[15:8]};
`else
    return w;
`endif
  endfunction
endpackage

// File: rtl/audio_stream_reader_if.sv
// SDRAM read port between the audio stream reader (master) and the RAM controller (slave).
interface audio_stream_reader_if;
  import audio_stream_pkg::*;

  logic                ram_re;
  logic [ADDR_W-1:0]   ram_address;
  logic                ram_op_begun;
  logic [SAMPLE_W-1:0] ram_rdata;
  logic                ram_rdata_valid;

  modport master (
    output ram_re, ram_address,
    input  ram_op_begun, ram_rdata, ram_rdata_valid
  );

  modport slave (
    input  ram_re, ram_address,
    output ram_op_begun, ram_rdata, ram_rdata_valid
  );
endinterface

// File: rtl/audio_stream_reader_fifo.sv
// Synchronous show-ahead sample FIFO with flush; DEPTH must be a power of two.
module sample_fifo
  import audio_stream_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    push,
  input  logic                    pop,
  input  logic [SAMPLE_W-1:0]     din,
  output logic [SAMPLE_W-1:0]     dout,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [SAMPLE_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;

  assign full = (count == DEPTH_C);
  assign empty = (count == '0);
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/audio_stream_reader.sv
// Audio stream reader: plays a double-buffered SDRAM region into a sample FIFO at the tick rate.
// Optional AUDIO_READER_BYTESWAP_EN (applied through audio_stream_pkg::order_word) byte-swaps samples.
module audio_stream_reader
  import audio_stream_pkg::*;
#(
  parameter logic [ADDR_W-1:0] HALF_WORDS = HALF_WORDS_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  clk50,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  loader_done,
  input  logic                  sample_tick,
  audio_stream_reader_if.master ram,
  output logic [SAMPLE_W-1:0]   sample_out,
  output logic                  sample_valid,
  output logic                  refill_half,
  output logic                  refill_req,
  output logic                  underrun
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  state_t state;
  logic [ADDR_W-1:0] offset, next_offset, addr_q;
  logic read_half, half_wait, re_q;
  logic half_end, fetch_ok, going_idle, push, pop;
  logic [CW-1:0] fifo_count;
  logic fifo_full, fifo_empty;
  logic [SAMPLE_W-1:0] fifo_dout;

  function automatic logic [ADDR_W-1:0] word_addr(input logic half, input logic [ADDR_W-1:0] off);
    return half ? HALF_WORDS + off : off;
  endfunction

  assign next_offset = offset + 1'b1;
  assign half_end = (next_offset == HALF_WORDS);
  // After a half switch, reading resumes only once the loader reports that half ready.
  assign fetch_ok = !half_wait || loader_done;
  assign going_idle = (!enable && (state == WAIT_LOAD || state == FETCH)) ||
                      (ram.ram_rdata_valid && (state == DRAIN || (state == WAIT_DATA && !enable)));
  assign push = (state == WAIT_DATA) && enable && ram.ram_rdata_valid && !fifo_full;
  assign pop = sample_tick && !fifo_empty && !going_idle;
  assign ram.ram_re = re_q;
  assign ram.ram_address = addr_q;

  sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk50),
    .rst_n (reset_n),
    .flush (going_idle),
    .push  (push),
    .pop   (pop),
    .din   (order_word(ram.ram_rdata)),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      offset <= '0;
      addr_q <= '0;
      read_half <= 1'b0;
      half_wait <= 1'b0;
      re_q <= 1'b0;
      sample_out <= '0;
      sample_valid <= 1'b0;
      refill_half <= 1'b0;
      refill_req <= 1'b0;
      underrun <= 1'b0;
    end else begin
      refill_req <= 1'b0;
      sample_valid <= 1'b0;
      if (going_idle) begin
        sample_out <= '0;
      end else if (sample_tick) begin
        if (!fifo_empty) begin
          sample_out <= fifo_dout;
          sample_valid <= 1'b1;
        end else if (state != IDLE && state != WAIT_LOAD) begin
          sample_out <= '0;
          sample_valid <= 1'b1;
          underrun <= 1'b1;
        end
      end

      case (state)
        IDLE: if (enable) begin
          state <= WAIT_LOAD;
          offset <= '0;
          addr_q <= '0;
          read_half <= 1'b0;
          half_wait <= 1'b0;
          underrun <= 1'b0;
        end
        WAIT_LOAD: begin
          if (!enable) state <= IDLE;
          else if (loader_done) state <= FETCH;
        end
        FETCH: begin
          if (!enable) begin
            state <= IDLE;
            re_q <= 1'b0;
          end else if (re_q) begin
            if (ram.ram_op_begun) begin
              re_q <= 1'b0;
              state <= WAIT_DATA;
            end
          end else if (fifo_count < DEPTH_C && fetch_ok) begin
            re_q <= 1'b1;
            half_wait <= 1'b0;
          end
        end
        WAIT_DATA: begin
          if (ram.ram_rdata_valid) begin
            if (!enable) begin
              state <= IDLE;
            end else begin
              state <= FETCH;
              if (half_end) begin
                offset <= '0;
                read_half <= !read_half;
                refill_half <= read_half;
                refill_req <= 1'b1;
                half_wait <= 1'b1;
                addr_q <= word_addr(!read_half, '0);
              end else begin
                offset <= next_offset;
                addr_q <= word_addr(read_half, next_offset);
              end
            end
          end else if (!enable) begin
            state <= DRAIN;
          end
        end
        DRAIN: if (ram.ram_rdata_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_audio_stream_reader.sv
// Scoreboard bench for audio_stream_reader (HALF_WORDS=16, FIFO_DEPTH=8) with a random-latency RAM model.
`timescale 1ns/1ps
module tb_audio_stream_reader;
  import audio_stream_pkg::*;

  localparam logic [24:0] HW = 25'd16;

  logic clk50 = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic loader_done = 1'b0;
  logic sample_tick = 1'b0;
  logic [15:0] sample_out;
  logic sample_valid, refill_half, refill_req, underrun;

  audio_stream_reader_if bus ();

  audio_stream_reader #(.HALF_WORDS(HW), .FIFO_DEPTH(8)) dut (
    .clk50        (clk50),
    .reset_n      (reset_n),
    .enable       (enable),
    .loader_done  (loader_done),
    .sample_tick  (sample_tick),
    .ram          (bus),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .refill_half  (refill_half),
    .refill_req   (refill_req),
    .underrun     (underrun)
  );

  always #10 clk50 = ~clk50;

  int checks = 0;
  int errors = 0;
  logic [15:0] mem [32];
  logic [15:0] exp_q [$];
  logic refill_q [$];
  logic [24:0] exp_addr = '0;
  bit ram_on = 1'b0;
  bit abort_mode = 1'b0;
  bit resp_busy = 1'b0;
  int reads = 0;
  int zero_cnt = 0;
  int refills_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] model_word(input logic [15:0] w);
`ifdef AUDIO_READER_BYTESWAP_EN
    return {w[7:0], w[15:8]};
`else
    return w;
`endif
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk50);
      #1;
    end
  endtask

  // RAM model: the reader walks words 0..31 circularly (two halves of 16).
  initial begin
    bus.ram_op_begun = 1'b0;
    bus.ram_rdata = '0;
    bus.ram_rdata_valid = 1'b0;
    forever begin
      cyc(1);
      if (ram_on && bus.ram_re) begin
        resp_busy = 1'b1;
        if (!abort_mode) check("ram_address", 32'(bus.ram_address), 32'(exp_addr));
        cyc($urandom_range(0, 2));
        bus.ram_op_begun = 1'b1;
        cyc(1);
        bus.ram_op_begun = 1'b0;
        if (abort_mode) begin
          cyc(2);
          bus.ram_rdata = 16'h5555;
        end else begin
          cyc($urandom_range(0, 3));
          bus.ram_rdata = mem[exp_addr[4:0]];
          exp_q.push_back(model_word(mem[exp_addr[4:0]]));
          reads++;
          if (exp_addr[3:0] == 4'hF) refill_q.push_back(exp_addr[4]);
          exp_addr = {20'd0, 5'(exp_addr[4:0] + 5'd1)};
        end
        bus.ram_rdata_valid = 1'b1;
        cyc(1);
        bus.ram_rdata_valid = 1'b0;
        resp_busy = 1'b0;
      end
    end
  end

  // Monitor: every presented sample and refill pulse is matched against the scoreboard.
  initial begin
    logic [15:0] e;
    forever begin
      cyc(1);
      if (sample_valid) begin
        if (sample_out == 16'h0) begin
          zero_cnt++;
          check("underrun_flag", 32'(underrun), 32'd1);
        end else if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sample_out: got %0h with nothing pending, required no sample", sample_out);
        end else begin
          e = exp_q.pop_front();
          check("sample_out", 32'(sample_out), 32'(e));
        end
      end
      if (refill_req) begin
        refills_seen++;
        if (refill_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL refill_req: got pulse with half %0d, required no pulse", refill_half);
        end else begin
          check("refill_half", 32'(refill_half), 32'(refill_q.pop_front()));
        end
      end
    end
  end

  task automatic quiesce_ram();
    ram_on = 1'b0;
    cyc(1);
    for (int i = 0; i < 30 && resp_busy; i++) cyc(1);
    check("ram_model_idle", 32'(resp_busy), 32'd0);
  endtask

  task automatic stream(input int n, input int tick_div);
    repeat (n) begin
      cyc(1);
      sample_tick = ($urandom_range(0, tick_div - 1) == 0);
    end
    cyc(1);
    sample_tick = 1'b0;
  endtask

  task automatic tick_pulse();
    sample_tick = 1'b1;
    cyc(1);
    sample_tick = 1'b0;
  endtask

  initial begin
    int zc0;
    for (int i = 0; i < 32; i++) mem[i] = 16'($urandom_range(1, 65535));
    mem[0] = 16'h1234;

    // Reset state
    cyc(3);
    check("rst_ram_re", 32'(bus.ram_re), 32'd0);
    check("rst_ram_address", 32'(bus.ram_address), 32'd0);
    check("rst_outputs", {sample_out, 12'd0, sample_valid, refill_half, refill_req, underrun}, 32'd0);
    @(negedge clk50);
    reset_n = 1'b1;

    // Fill with no ticks: exactly eight reads, then the request line rests low
    exp_addr = '0;
    reads = 0;
    ram_on = 1'b1;
    loader_done = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 300 && reads < 8; i++) cyc(1);
    cyc(30);
    check("reads_no_ticks", 32'(reads), 32'd8);
    check("ram_re_when_full", 32'(bus.ram_re), 32'd0);

    // First tick presents the word stored at address 0 one cycle later
    tick_pulse();
    check("first_sample_valid", 32'(sample_valid), 32'd1);
    check("first_sample_out", 32'(sample_out), 32'(model_word(16'h1234)));

    // Random streaming across several half boundaries
    stream(800, 6);
    check("refills_seen", 32'(refills_seen >= 2), 32'd1);

    // Starve the FIFO: ticks produce zero samples and a sticky underrun
    quiesce_ram();
    zc0 = zero_cnt;
    repeat (20) begin
      tick_pulse();
      cyc(2);
    end
    check("underrun_zero_samples", 32'((zero_cnt - zc0) >= 10), 32'd1);
    check("fifo_drained", 32'(exp_q.size()), 32'd0);
    tick_pulse();
    check("underrun_tick_valid", 32'(sample_valid), 32'd1);
    check("underrun_tick_out", 32'(sample_out), 32'd0);
    cyc(10);
    check("underrun_sticky", 32'(underrun), 32'd1);

    // Disable while a read is outstanding: late data discarded, reader idles
    check("ram_re_pending", 32'(bus.ram_re), 32'd1);
    abort_mode = 1'b1;
    ram_on = 1'b1;
    for (int i = 0; i < 20 && bus.ram_re; i++) cyc(1);
    enable = 1'b0;
    ram_on = 1'b0;
    for (int i = 0; i < 20 && resp_busy; i++) cyc(1);
    abort_mode = 1'b0;
    check("drain_ram_re", 32'(bus.ram_re), 32'd0);
    check("drain_sample_out", 32'(sample_out), 32'd0);
    check("idle_underrun_held", 32'(underrun), 32'd1);
    tick_pulse();
    check("idle_tick_valid", 32'(sample_valid), 32'd0);

    // Restart: underrun clears and playback resumes from address 0
    exp_addr = '0;
    ram_on = 1'b1;
    enable = 1'b1;
    cyc(3);
    check("underrun_cleared", 32'(underrun), 32'd0);
    stream(250, 5);

    // Asynchronous reset in the middle of fetching
    quiesce_ram();
    repeat (3) begin
      tick_pulse();
      cyc(3);
    end
    cyc(3);
    check("ram_re_before_reset", 32'(bus.ram_re), 32'd1);
    @(posedge clk50);
    #5;
    reset_n = 1'b0;
    #1;
    check("arst_ram_re", 32'(bus.ram_re), 32'd0);
    check("arst_ram_address", 32'(bus.ram_address), 32'd0);
    check("arst_outputs", {sample_out, 12'd0, sample_valid, refill_half, refill_req, underrun}, 32'd0);
    exp_q.delete();
    refill_q.delete();
    enable = 1'b0;
    repeat (2) @(negedge clk50);
    reset_n = 1'b1;
    cyc(1);
    exp_addr = '0;
    ram_on = 1'b1;
    enable = 1'b1;
    stream(300, 6);

    // Drain what is left in the FIFO
    quiesce_ram();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
      tick_pulse();
      cyc(1);
    end
    cyc(3);
    check("final_drain", 32'(exp_q.size()), 32'd0);
    check("refill_pending", 32'(refill_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end
endmodule
